game_ctl: RTL and testbench

GAME_CTL -- requirements
Module: game_ctl

---
 rtl/game_ctl_if.sv | 24 ++
 rtl/game_ctl.sv | 171 +++++++++++++++++
 tb/tb_game_ctl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/game_ctl_if.sv
// Mouse-in / game-state-out bundle for the tic-tac-toe controller.
// The master drives pointer and buttons; the slave (game_ctl) drives game state.
interface game_ctl_if;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  game_state;
  logic [1:0]  winner;
  logic [3:0]  win_line;
  logic [3:0]  move_cnt;

  modport master (
    output xpos, ypos, left, right,
    input  board, turn, game_state, winner, win_line, move_cnt
  );

  modport slave (
    input  xpos, ypos, left, right,
    output board, turn, game_state, winner, win_line, move_cnt
  );
endinterface

// File: rtl/game_ctl.sv
// Tic-tac-toe game controller: decodes mouse clicks onto a 3x3 board,
// places marks, and detects win/draw one cycle after each move.
module game_ctl #(
  parameter int unsigned BOARD_X   = 212,
  parameter int unsigned BOARD_Y   = 84,
  parameter int unsigned CELL_SIZE = 200
) (
  input  logic pclk,
  input  logic rst,
  game_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    StPlay  = 2'b00,
    StCheck = 2'b01,
    StWin   = 2'b10,
    StDraw  = 2'b11
  } state_e;

  localparam logic [12:0] X0 = 13'(BOARD_X);
  localparam logic [12:0] X1 = 13'(BOARD_X + CELL_SIZE);
  localparam logic [12:0] X2 = 13'(BOARD_X + 2 * CELL_SIZE);
  localparam logic [12:0] X3 = 13'(BOARD_X + 3 * CELL_SIZE);
  localparam logic [12:0] Y0 = 13'(BOARD_Y);
  localparam logic [12:0] Y1 = 13'(BOARD_Y + CELL_SIZE);
  localparam logic [12:0] Y2 = 13'(BOARD_Y + 2 * CELL_SIZE);
  localparam logic [12:0] Y3 = 13'(BOARD_Y + 3 * CELL_SIZE);

  // Cell indices of each line, in win_line order.
  localparam int unsigned Lines [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [1:0]  winner_q, winner_d;
  logic [3:0]  win_line_q, win_line_d;
  logic [3:0]  move_cnt_q, move_cnt_d;
  logic        left_d_q, left_d_d;
  logic        right_d_q, right_d_d;

  logic        click, restart;
  logic [12:0] x_ext, y_ext;
  logic [1:0]  col, row;
  logic        col_ok, row_ok;
  logic [3:0]  cell_idx;
  logic [4:0]  cell_bit;
  logic [1:0]  cell_mark;
  logic [1:0]  mark;
  logic        line_hit;
  logic [3:0]  line_idx;

  assign click   = bus.left & ~left_d_q;
  assign restart = bus.right & ~right_d_q;
  assign x_ext   = {1'b0, bus.xpos};
  assign y_ext   = {1'b0, bus.ypos};
  assign mark    = turn_q ? 2'b10 : 2'b01;

  always_comb begin
    col    = 2'd0;
    col_ok = 1'b1;
    if (x_ext >= X0 && x_ext < X1)      col = 2'd0;
    else if (x_ext >= X1 && x_ext < X2) col = 2'd1;
    else if (x_ext >= X2 && x_ext < X3) col = 2'd2;
    else                                col_ok = 1'b0;
  end

  always_comb begin
    row    = 2'd0;
    row_ok = 1'b1;
    if (y_ext >= Y0 && y_ext < Y1)      row = 2'd0;
    else if (y_ext >= Y1 && y_ext < Y2) row = 2'd1;
    else if (y_ext >= Y2 && y_ext < Y3) row = 2'd2;
    else                                row_ok = 1'b0;
  end

  assign cell_idx  = {2'b00, row} + {1'b0, row, 1'b0} + {2'b00, col};
  assign cell_bit  = {cell_idx, 1'b0};
  assign cell_mark = board_q[cell_bit +: 2];

  // Descending scan so the lowest complete line index wins.
  always_comb begin
    line_hit = 1'b0;
    line_idx = 4'hF;
    for (int i = 7; i >= 0; i--) begin
      if (board_q[2 * Lines[i][0] +: 2] == mark &&
          board_q[2 * Lines[i][1] +: 2] == mark &&
          board_q[2 * Lines[i][2] +: 2] == mark) begin
        line_hit = 1'b1;
        line_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    move_cnt_d = move_cnt_q;
    left_d_d   = bus.left;
    right_d_d  = bus.right;

    if (restart) begin
      state_d    = StPlay;
      board_d    = '0;
      turn_d     = 1'b0;
      winner_d   = 2'b00;
      win_line_d = 4'hF;
      move_cnt_d = 4'd0;
    end else begin
      case (state_q)
        StPlay: begin
          if (click && col_ok && row_ok && cell_mark == 2'b00) begin
            board_d[cell_bit +: 2] = mark;
            move_cnt_d             = move_cnt_q + 4'd1;
            state_d                = StCheck;
          end
        end
        StCheck: begin
          if (line_hit) begin
            state_d    = StWin;
            winner_d   = mark;
            win_line_d = line_idx;
          end else if (move_cnt_q == 4'd9) begin
            state_d = StDraw;
          end else begin
            turn_d  = ~turn_q;
            state_d = StPlay;
          end
        end
        default: ;
      endcase
    end
  end

  // Button history resets high so a button held through reset is not an event.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= StPlay;
      board_q    <= '0;
      turn_q     <= 1'b0;
      winner_q   <= 2'b00;
      win_line_q <= 4'hF;
      move_cnt_q <= 4'd0;
      left_d_q   <= 1'b1;
      right_d_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      move_cnt_q <= move_cnt_d;
      left_d_q   <= left_d_d;
      right_d_q  <= right_d_d;
    end
  end

  assign bus.board      = board_q;
  assign bus.turn       = turn_q;
  assign bus.game_state = state_q;
  assign bus.winner     = winner_q;
  assign bus.win_line   = win_line_q;
  assign bus.move_cnt   = move_cnt_q;

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: clicks, boundaries, win/draw, restart and reset cases.
module tb_game_ctl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  game_ctl_if bus ();

  game_ctl #(
    .BOARD_X  (212),
    .BOARD_Y  (84),
    .CELL_SIZE(200)
  ) dut (
    .pclk(clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [11:0] x, input logic [11:0] y);
    bus.xpos = x;
    bus.ypos = y;
    bus.left = 1'b1;
    step();
    bus.left = 1'b0;
    step();
  endtask

  task automatic click_cell(input int k);
    press(12'(312 + 200 * (k % 3)), 12'(184 + 200 * (k / 3)));
  endtask

  task automatic do_restart();
    bus.right = 1'b1;
    step();
    bus.right = 1'b0;
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".board"}, 32'(bus.board), 32'h0);
    check_val({tag, ".turn"}, 32'(bus.turn), 32'h0);
    check_val({tag, ".state"}, 32'(bus.game_state), 32'h0);
    check_val({tag, ".winner"}, 32'(bus.winner), 32'h0);
    check_val({tag, ".win_line"}, 32'(bus.win_line), 32'hF);
    check_val({tag, ".move_cnt"}, 32'(bus.move_cnt), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.xpos  = 12'd312;
    bus.ypos  = 12'd184;
    bus.left  = 1'b1;
    bus.right = 1'b1;
    repeat (3) step();
    check_reset_vals("reset");

    // Buttons held through reset must not fire.
    rst = 1'b0;
    repeat (3) step();
    check_val("held_thru_rst.board", 32'(bus.board), 32'h0);
    check_val("held_thru_rst.state", 32'(bus.game_state), 32'h0);
    bus.left  = 1'b0;
    bus.right = 1'b0;
    step();

    // First move and its two-edge timing.
    bus.xpos = 12'd312;
    bus.ypos = 12'd184;
    bus.left = 1'b1;
    step();
    check_val("mv1.board", 32'(bus.board), 32'h1);
    check_val("mv1.cnt", 32'(bus.move_cnt), 32'd1);
    check_val("mv1.state_check", 32'(bus.game_state), 32'd1);
    check_val("mv1.turn_before", 32'(bus.turn), 32'd0);
    bus.left = 1'b0;
    step();
    check_val("mv1.turn", 32'(bus.turn), 32'd1);
    check_val("mv1.state", 32'(bus.game_state), 32'd0);

    // Just outside the board on either side.
    press(12'd211, 12'd184);
    press(12'd812, 12'd184);
    check_val("oob.board", 32'(bus.board), 32'h1);
    check_val("oob.turn", 32'(bus.turn), 32'd1);
    check_val("oob.cnt", 32'(bus.move_cnt), 32'd1);

    do_restart();
    check_reset_vals("restart");
    press(12'd411, 12'd184);
    check_val("x411.board", 32'(bus.board), 32'h1);

    do_restart();
    press(12'd412, 12'd184);
    check_val("x412.board", 32'(bus.board), 32'h4);

    // Occupied cell.
    do_restart();
    click_cell(0);
    click_cell(0);
    check_val("occ.board", 32'(bus.board), 32'h1);
    check_val("occ.turn", 32'(bus.turn), 32'd1);
    check_val("occ.cnt", 32'(bus.move_cnt), 32'd1);

    // X wins on the top row.
    do_restart();
    click_cell(0); click_cell(3); click_cell(1); click_cell(4); click_cell(2);
    check_val("xwin.state", 32'(bus.game_state), 32'd2);
    check_val("xwin.winner", 32'(bus.winner), 32'd1);
    check_val("xwin.line", 32'(bus.win_line), 32'd0);
    check_val("xwin.board", 32'(bus.board), 32'h295);
    check_val("xwin.cnt", 32'(bus.move_cnt), 32'd5);
    click_cell(8);
    check_val("xwin.late_board", 32'(bus.board), 32'h295);
    check_val("xwin.late_state", 32'(bus.game_state), 32'd2);

    // O wins on the middle row.
    do_restart();
    click_cell(0); click_cell(3); click_cell(1); click_cell(4); click_cell(8); click_cell(5);
    check_val("owin.state", 32'(bus.game_state), 32'd2);
    check_val("owin.winner", 32'(bus.winner), 32'd2);
    check_val("owin.line", 32'(bus.win_line), 32'd1);
    check_val("owin.board", 32'(bus.board), 32'h10A85);

    // Full board, no line.
    do_restart();
    click_cell(0); click_cell(1); click_cell(2); click_cell(4); click_cell(3);
    click_cell(5); click_cell(7); click_cell(6); click_cell(8);
    check_val("draw.state", 32'(bus.game_state), 32'd3);
    check_val("draw.cnt", 32'(bus.move_cnt), 32'd9);
    check_val("draw.winner", 32'(bus.winner), 32'd0);
    check_val("draw.line", 32'(bus.win_line), 32'hF);
    check_val("draw.board", 32'(bus.board), 32'h16A59);

    // Ninth move completes column 0: win beats draw.
    do_restart();
    click_cell(0); click_cell(1); click_cell(2); click_cell(4); click_cell(3);
    click_cell(5); click_cell(7); click_cell(8); click_cell(6);
    check_val("win9.state", 32'(bus.game_state), 32'd2);
    check_val("win9.winner", 32'(bus.winner), 32'd1);
    check_val("win9.line", 32'(bus.win_line), 32'd3);
    check_val("win9.cnt", 32'(bus.move_cnt), 32'd9);

    // Simultaneous click and restart mid-game.
    do_restart();
    click_cell(0);
    bus.xpos  = 12'd512;
    bus.ypos  = 12'd184;
    bus.left  = 1'b1;
    bus.right = 1'b1;
    step();
    check_val("both.board", 32'(bus.board), 32'h0);
    check_val("both.turn", 32'(bus.turn), 32'd0);
    check_val("both.state", 32'(bus.game_state), 32'd0);
    check_val("both.cnt", 32'(bus.move_cnt), 32'd0);
    bus.left  = 1'b0;
    bus.right = 1'b0;
    step();

    // Long hold on cell 4 gives one move.
    bus.xpos = 12'd512;
    bus.ypos = 12'd384;
    bus.left = 1'b1;
    repeat (1000) step();
    bus.left = 1'b0;
    step();
    check_val("hold.board", 32'(bus.board), 32'h100);
    check_val("hold.cnt", 32'(bus.move_cnt), 32'd1);
    check_val("hold.turn", 32'(bus.turn), 32'd1);

    // Reset landing on the CHECK cycle.
    do_restart();
    bus.xpos = 12'd512;
    bus.ypos = 12'd384;
    bus.left = 1'b1;
    step();
    bus.left = 1'b0;
    check_val("rstchk.in_check", 32'(bus.game_state), 32'd1);
    rst = 1'b1;
    step();
    check_reset_vals("rstchk");
    rst = 1'b0;
    repeat (2) step();
    check_val("rstchk.after_board", 32'(bus.board), 32'h0);
    check_val("rstchk.after_turn", 32'(bus.turn), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
